alu_writeback_stage: RTL

- Downstream consumer of the 32-bit ALU. Captures the ALU outputs: data_result, isNotEqual, isLessThan and overflow.
- Resolves the bne/blt branch decision for the instruction.
- Rewrites add/addi/sub overflow into the rstatus exception write: register 30 receives code 1, 2 or 3.
- Presents one writeback/branch record per instruction to the register-file/PC stage over a valid/ready handshake, with a 2-entry skid buffer so upstream can run at full rate.

---
 rtl/alu_wb_pkg.sv | 37 +++
 rtl/alu_wb_skid.sv | 73 +++++++
 rtl/alu_writeback_stage.sv | 100 ++++++++++
 3 files changed

// File: rtl/alu_wb_pkg.sv
// Shared types for the ALU writeback stage: instruction classes, rstatus codes, record layout.
package alu_wb_pkg;

  typedef enum logic [2:0] {
    K_ADD   = 3'd0,
    K_ADDI  = 3'd1,
    K_SUB   = 3'd2,
    K_LOGIC = 3'd3,
    K_BNE   = 3'd4,
    K_BLT   = 3'd5,
    K_NOP   = 3'd6
  } kind_e;

  localparam logic [31:0] RS_ADD  = 32'd1;
  localparam logic [31:0] RS_ADDI = 32'd2;
  localparam logic [31:0] RS_SUB  = 32'd3;

  // One writeback/branch record handed to the register-file/PC stage.
  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        branch_taken;
    logic [31:0] target;
    logic        exception;
  } wb_rec_t;

  // rstatus code written for an overflowing arithmetic instruction.
  function automatic logic [31:0] rstatus_code(kind_e kind);
    case (kind)
      K_ADDI:  return RS_ADDI;
      K_SUB:   return RS_SUB;
      default: return RS_ADD;
    endcase
  endfunction

endpackage

// File: rtl/alu_wb_skid.sv
// Two-entry valid/ready skid buffer; in_ready depends only on registered state.
module alu_wb_skid #(
  parameter int unsigned Width = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Width-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out_data
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e           state_q, state_d;
  logic [Width-1:0] main_q, main_d;
  logic [Width-1:0] skid_q, skid_d;
  logic             accept, drain;

  assign in_ready  = (state_q != StFull);
  assign out_valid = (state_q != StEmpty);
  assign out_data  = main_q;
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;

  // Next-state and data movement; main always holds the oldest record.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          main_d  = in_data;
          state_d = StOne;
        end
      end
      StOne: begin
        if (accept && drain) begin
          main_d = in_data;
        end else if (accept) begin
          skid_d  = in_data;
          state_d = StFull;
        end else if (drain) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (drain) begin
          main_d  = skid_q;
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  // State and storage registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: rtl/alu_writeback_stage.sv
// ALU writeback stage: forms writeback/branch records, buffers them, counts exceptions.
module alu_writeback_stage
  import alu_wb_pkg::*;
#(
  parameter int unsigned EXC_CNT_W   = 16,
  parameter int unsigned RSTATUS_REG = 30
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_result,
  input  logic                 in_isNotEqual,
  input  logic                 in_isLessThan,
  input  logic                 in_overflow,
  input  logic [2:0]           in_kind,
  input  logic [4:0]           in_rd,
  input  logic [31:0]          in_target,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_we,
  output logic [4:0]           out_rd,
  output logic [31:0]          out_data,
  output logic                 out_branch_taken,
  output logic [31:0]          out_target,
  output logic                 out_exception,
  output logic [EXC_CNT_W-1:0] exc_count
);

  kind_e                kind;
  wb_rec_t              in_rec;
  wb_rec_t              out_rec;
  logic [EXC_CNT_W-1:0] exc_count_q, exc_count_d;

  assign kind = kind_e'(in_kind);

  // Record formation; overflowing arithmetic becomes an rstatus write.
  always_comb begin
    in_rec        = '0;
    in_rec.rd     = in_rd;
    in_rec.data   = in_result;
    in_rec.target = in_target;
    case (kind)
      K_ADD, K_ADDI, K_SUB: begin
        if (in_overflow) begin
          in_rec.we        = 1'b1;
          in_rec.rd        = 5'(RSTATUS_REG);
          in_rec.data      = rstatus_code(kind);
          in_rec.exception = 1'b1;
        end else begin
          in_rec.we = (in_rd != 5'd0);
        end
      end
      K_LOGIC: in_rec.we = (in_rd != 5'd0);
      K_BNE:   in_rec.branch_taken = in_isNotEqual;
      // isLessThan already folds in the subtract's overflow.
      K_BLT:   in_rec.branch_taken = in_isLessThan;
      default: ;
    endcase
  end

  alu_wb_skid #(
    .Width($bits(wb_rec_t))
  ) u_skid (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_rec),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_rec)
  );

  assign out_we           = out_rec.we;
  assign out_rd           = out_rec.rd;
  assign out_data         = out_rec.data;
  assign out_branch_taken = out_rec.branch_taken;
  assign out_target       = out_rec.target;
  assign out_exception    = out_rec.exception;
  assign exc_count        = exc_count_q;

  // Saturating count of exception records leaving the stage.
  always_comb begin
    exc_count_d = exc_count_q;
    if (out_valid && out_ready && out_rec.exception && (exc_count_q != '1)) begin
      exc_count_d = exc_count_q + EXC_CNT_W'(1);
    end
  end

  // Exception counter register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      exc_count_q <= '0;
    end else begin
      exc_count_q <= exc_count_d;
    end
  end

endmodule
